// File: rtl/sigcapture.sv
// sigcapture: threshold-triggered single-shot capture buffer with replay; define SIGCAP_PRETRIG_EN for pre-trigger history
module sigcapture #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] level,
  input  logic               arm,
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               armed,
  output logic               ready
);
  localparam int N = 1 << A_WIDTH;
`ifdef SIGCAP_PRETRIG_EN
  localparam logic PRE = 1'b1;
  localparam int   TGT = N / 2;
`else
  localparam logic PRE = 1'b0;
  localparam int   TGT = N;
`endif
  localparam logic [A_WIDTH-1:0] ONE  = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] HALF = A_WIDTH'(N / 2);
  localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(TGT - 1);
  localparam logic [A_WIDTH-1:0] TOP  = A_WIDTH'(N - 1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READY} state_t;
  state_t             state_q;
  logic [D_WIDTH-1:0] mem [N];
  logic [D_WIDTH-1:0] prev_q;
  logic               prev_vld_q;
  logic [A_WIDTH-1:0] wr_ptr_q;
  logic [A_WIDTH-1:0] rd_ptr_q;
  logic [A_WIDTH-1:0] cnt_q;
  logic               trig;
  logic               we;
  // rising crossing needs a previous sample from this arming; history writes only with pre-trigger enabled
  always_comb begin
    trig = (state_q == ARMED) && en && prev_vld_q && (prev_q < level) && (din >= level);
    we   = ((state_q == ARMED) && en && (PRE || trig)) || ((state_q == CAPTURE) && en);
  end
  // sample RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= din;
  end
  // capture/readout controller with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      armed      <= 1'b0;
      ready      <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (we) wr_ptr_q <= wr_ptr_q + ONE;
      case (state_q)
        IDLE: if (arm) begin
          state_q    <= ARMED;
          armed      <= 1'b1;
          prev_vld_q <= 1'b0;
          if (!PRE) wr_ptr_q <= '0;
        end
        ARMED: if (en) begin
          prev_q     <= din;
          prev_vld_q <= 1'b1;
          if (trig) begin
            armed    <= 1'b0;
            rd_ptr_q <= PRE ? wr_ptr_q - HALF : '0;
            cnt_q    <= (LAST == '0) ? '0 : ONE;
            state_q  <= (LAST == '0) ? READY : CAPTURE;
            ready    <= (LAST == '0);
          end
        end
        CAPTURE: if (en) begin
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_q <= READY;
            ready   <= 1'b1;
          end
        end
        READY: if (rd_en) begin
          dout       <= mem[rd_ptr_q];
          dout_valid <= 1'b1;
          rd_ptr_q   <= rd_ptr_q + ONE;
          cnt_q      <= (cnt_q == TOP) ? '0 : cnt_q + ONE;
          if (cnt_q == TOP) begin
            state_q <= IDLE;
            ready   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/sigcapture.md
# sigcapture

Single-shot signal capture buffer: the receiving end of the sine generator's sample stream. It watches an incoming sample stream for a rising crossing of a programmable threshold. It then stores a full buffer of samples in internal RAM and streams them back out on a read strobe for display or checking. It sits downstream of the signal-generator/ROM path, on the same clock, and works as a capture-and-replay scope channel.

## Interface
Parameters:
- A_WIDTH, 8, buffer address width; depth N = 2^A_WIDTH
- D_WIDTH, 8, sample width

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  sample strobe; din is valid this cycle
- din  in  D_WIDTH  incoming sample, unsigned
- level  in  D_WIDTH  trigger threshold, unsigned
- arm  in  1  one-cycle request to start a capture
- rd_en  in  1  readout request, one sample per asserted cycle
- dout  out  D_WIDTH  readout sample, registered
- dout_valid  out  1  dout holds a new sample this cycle
- armed  out  1  high in state ARMED
- ready  out  1  high in state READY (buffer full, readout allowed)

## Operation
- States: IDLE, ARMED, CAPTURE, READY.
- Reset (rst=0 at an edge) forces IDLE, dout=0, dout_valid=0, armed=0, ready=0, and all pointers and counters to 0. RAM contents are not cleared.
- IDLE: arm=1 moves to ARMED and clears the prev-sample-valid flag. en, din and rd_en are ignored.
- ARMED: on each en, the block registers din as prev and sets prev-sample-valid.
  - Trigger condition: en=1, prev valid, prev < level, and din >= level (unsigned compare).
  - The first sample after arming never triggers.
- Trigger: the triggering sample is written to RAM as post-trigger sample 0, and the state moves to CAPTURE.
- CAPTURE: each en writes din to wr_ptr, then wr_ptr increments modulo N. When the last required sample is written, the state moves to READY.
- READY: each rd_en=1 reads RAM[rd_ptr], then rd_ptr increments modulo N.
  - After the N-th read is accepted, the state moves to IDLE.
  - The buffer must be read completely before a new arm is honoured.
- arm is ignored outside IDLE. rd_en is ignored outside READY. en is ignored in IDLE and READY.
- Arithmetic: all pointers are A_WIDTH bits and wrap modulo N. No saturation.

## Timing
- Trigger-sample cycle t (en=1): that sample is written at edge t. State is CAPTURE from t+1 and armed falls at t+1.
- The last capture write at cycle t makes ready rise at t+1.
- A read with rd_en=1 at cycle t drives dout and dout_valid=1 at t+1.
  - dout_valid is high for exactly one cycle per accepted read.
  - dout holds its value otherwise.
- Back-to-back rd_en gives one sample per cycle.
- The N-th accepted read at cycle t: ready falls at t+1, the final dout_valid still appears at t+1, and arm is honoured from t+1.
- arm and en in the same IDLE cycle: that sample is not seen. Sampling starts the next cycle.
- Reset mid-capture or mid-readout: IDLE on the next cycle, dout_valid=0, and any partial readout is abandoned.

## Configuration
- SIGCAP_PRETRIG_EN defined (pre-trigger history):
  - In ARMED, every en also writes din to wr_ptr and increments wr_ptr (circular history).
  - At trigger, the trigger address T=wr_ptr is latched and the sample is written there.
  - CAPTURE then writes until N/2 post-trigger samples (including the trigger sample) are stored.
  - Readout starts at rd_ptr = T − N/2 mod N.
  - If fewer than N/2 samples arrived before the trigger, the pre-trigger region holds stale RAM contents. This is permitted.
- SIGCAP_PRETRIG_EN undefined:
  - No writes occur in ARMED.
  - The trigger sample is written at address 0.
  - CAPTURE stores N samples in total.
  - Readout starts at address 0.

## Test plan
All scenarios use defaults (N=256, D_WIDTH=8), reset first, then check outputs: dout=0, dout_valid=0, armed=0, ready=0.
- No-pretrig trigger: arm, then en every cycle with a ramp din=0,1,2,…,255,0,… and level=100.
  - armed is high until the 100 sample, then ready rises 256 samples later.
  - 256 rd_en cycles read out 100,101,…,255,0,…,99, then ready=0.
- Pretrig (SIGCAP_PRETRIG_EN): same ramp, level=200.
  - Readout is 72,73,…,255,0,…,71.
  - ready rises 128 samples after the trigger.
- First-sample suppression: arm, then din held at 250 with level=100.
  - No trigger ever occurs; armed stays 1.
  - Then din=50, 150 triggers on the 150 sample.
- Ignored controls:
  - arm pulsed during CAPTURE and READY changes nothing.
  - rd_en in IDLE or ARMED gives dout_valid=0.
  - en gaps during CAPTURE stall the write count.
- Reset mid-operation:
  - rst=0 after 40 capture writes gives IDLE next cycle, with ready=0 and armed=0.
  - A subsequent full capture reads back correctly.
- Read throttling: rd_en alternating 1/0 during readout.
  - dout_valid follows one cycle later.
  - Sequence is intact, with no skipped or duplicated samples.
